// File: rtl/plane_bus_if.sv
// ---------------------------------------------------------------------------
// plane_bus_if
// Bundles the frame-source handshake and the shared plane-load bus between
// plane_bus_master and its environment.
//
// Signals:
//   frame_start  one-cycle request to load a full frame (all planes)
//   clear_start  one-cycle request to broadcast clear-memory
//   pix_data     brightness value (C_WIDTH), plane-major, output-index order
//   pix_valid    pix_data valid
//   pix_ready    master accepts pix_data this cycle when pix_valid=1
//   busy         master is running a sequence
//   frame_done   one-cycle pulse when a frame or clear sequence completes
//   bus_data     command/data byte (D_WIDTH)
//   bus_rs       1 = command, 0 = memory data
//   bus_en       strobe; receivers latch on its falling edge
//   bus_cs       one-hot plane select (PLANES), all ones for broadcast
//
// Modports: master (plane_bus_master side), slave (source/receiver side).
// ---------------------------------------------------------------------------
interface plane_bus_if #(
    parameter int PLANES  = 8,
    parameter int D_WIDTH = 8,
    parameter int C_WIDTH = 5
) ();
    logic               frame_start;
    logic               clear_start;
    logic [C_WIDTH-1:0] pix_data;
    logic               pix_valid;
    logic               pix_ready;
    logic               busy;
    logic               frame_done;
    logic [D_WIDTH-1:0] bus_data;
    logic               bus_rs;
    logic               bus_en;
    logic [PLANES-1:0]  bus_cs;

    modport master (
        input  frame_start, clear_start, pix_data, pix_valid,
        output pix_ready, busy, frame_done, bus_data, bus_rs, bus_en, bus_cs
    );

    modport slave (
        output frame_start, clear_start, pix_data, pix_valid,
        input  pix_ready, busy, frame_done, bus_data, bus_rs, bus_en, bus_cs
    );
endinterface

// File: rtl/plane_bus_master.sv
// ---------------------------------------------------------------------------
// plane_bus_master
// Drives the shared plane-load bus feeding the per-plane PWM controllers of
// the LED cube. A frame request walks every plane (one-hot bus_cs) issuing
// increment-mode, set-address-0, OUT_NUM data writes taken from the pixel
// stream, and PWM-enable. A clear request broadcasts clear-memory.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    plane_bus_if.master: start requests, pixel handshake, busy,
//          frame_done and the registered bus outputs
//          (bus_data, bus_rs, bus_en, bus_cs)
// ---------------------------------------------------------------------------
module plane_bus_master #(
    parameter int PLANES        = 8,
    parameter int OUT_NUM       = 64,
    parameter int D_WIDTH       = 8,
    parameter int C_WIDTH       = 5,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input logic         clk,
    input logic         reset,
    plane_bus_if.master bus
);
    localparam int CNT_MAX = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PIX_W   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;

    localparam logic [D_WIDTH-1:0] CMD_CLEAR = D_WIDTH'(8'h01);
    localparam logic [D_WIDTH-1:0] CMD_INC   = D_WIDTH'(8'h06);
    localparam logic [D_WIDTH-1:0] CMD_ADDR0 = D_WIDTH'(8'h80);
    localparam logic [D_WIDTH-1:0] CMD_PWM   = D_WIDTH'(8'h0C);

    typedef enum logic [2:0] {IDLE, CMD, WAIT_PIX, STROBE, HOLD, DONE} state_t;
    // Kind of the next transaction to launch; K_END means the sequence is over.
    typedef enum logic [2:0] {K_INC, K_ADDR, K_DATA, K_PWM, K_CLR, K_END} kind_t;

    state_t             state, stateNext;
    kind_t              pend, pendNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [PIX_W-1:0]   pixCnt, pixCntNext;
    logic [PLANE_W-1:0] planeCnt, planeCntNext;
    logic [D_WIDTH-1:0] busData, busDataNext;
    logic               busRs, busRsNext;
    logic               busEn, busEnNext;
    logic [PLANES-1:0]  busCs, busCsNext;
    logic               launch;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pend     <= K_END;
            cnt      <= '0;
            pixCnt   <= '0;
            planeCnt <= '0;
            busData  <= '0;
            busRs    <= 1'b0;
            busEn    <= 1'b0;
            busCs    <= '0;
        end else begin
            state    <= stateNext;
            pend     <= pendNext;
            cnt      <= cntNext;
            pixCnt   <= pixCntNext;
            planeCnt <= planeCntNext;
            busData  <= busDataNext;
            busRs    <= busRsNext;
            busEn    <= busEnNext;
            busCs    <= busCsNext;
        end
    end

    // CMD and WAIT_PIX double as the final hold cycle of the previous
    // transaction (bus_en low, bus values untouched), so launching from them
    // keeps back-to-back transactions gap-free. Only the last transaction of
    // a sequence spends its whole hold window in HOLD before DONE.
    always_comb begin
        stateNext    = state;
        pendNext     = pend;
        cntNext      = cnt;
        pixCntNext   = pixCnt;
        planeCntNext = planeCnt;
        busDataNext  = busData;
        busRsNext    = busRs;
        busEnNext    = 1'b0;
        busCsNext    = busCs;
        launch       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.clear_start) begin
                    pendNext  = K_CLR;
                    stateNext = CMD;
                end else if (bus.frame_start) begin
                    pendNext     = K_INC;
                    planeCntNext = '0;
                    pixCntNext   = '0;
                    stateNext    = CMD;
                end
            end
            CMD: launch = 1'b1;
            WAIT_PIX: launch = bus.pix_valid;
            STROBE: begin
                if (int'(cnt) == STROBE_CYCLES - 1) begin
                    cntNext = '0;
                    if (pend == K_END || HOLD_CYCLES > 1) stateNext = HOLD;
                    else if (pend == K_DATA)              stateNext = WAIT_PIX;
                    else                                  stateNext = CMD;
                end else begin
                    cntNext   = cnt + CNT_W'(1);
                    busEnNext = 1'b1;
                end
            end
            HOLD: begin
                cntNext = cnt + CNT_W'(1);
                if (pend == K_END) begin
                    if (int'(cnt) == HOLD_CYCLES - 1) begin
                        stateNext   = DONE;
                        busDataNext = '0;
                        busRsNext   = 1'b0;
                        busCsNext   = '0;
                    end
                end else if (int'(cnt) == HOLD_CYCLES - 2) begin
                    cntNext   = '0;
                    stateNext = (pend == K_DATA) ? WAIT_PIX : CMD;
                end
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        if (launch) begin
            busEnNext = 1'b1;
            stateNext = STROBE;
            cntNext   = '0;
            busRsNext = 1'b1;
            busCsNext = PLANES'(1) << planeCnt;
            case (pend)
                K_CLR: begin
                    busDataNext = CMD_CLEAR;
                    busCsNext   = '1;
                    pendNext    = K_END;
                end
                K_INC: begin
                    busDataNext = CMD_INC;
                    pendNext    = K_ADDR;
                end
                K_ADDR: begin
                    busDataNext = CMD_ADDR0;
                    pixCntNext  = '0;
                    pendNext    = K_DATA;
                end
                K_DATA: begin
                    busDataNext = D_WIDTH'(bus.pix_data);
                    busRsNext   = 1'b0;
                    if (pixCnt == PIX_W'(OUT_NUM - 1)) begin
                        pixCntNext = '0;
                        pendNext   = K_PWM;
                    end else begin
                        pixCntNext = pixCnt + PIX_W'(1);
                    end
                end
                K_PWM: begin
                    busDataNext = CMD_PWM;
                    if (planeCnt == PLANE_W'(PLANES - 1)) begin
                        pendNext = K_END;
                    end else begin
                        planeCntNext = planeCnt + PLANE_W'(1);
                        pendNext     = K_INC;
                    end
                end
                default: begin
                    busEnNext   = 1'b0;
                    stateNext   = IDLE;
                    busRsNext   = busRs;
                    busCsNext   = busCs;
                end
            endcase
        end
    end

    assign bus.bus_data   = busData;
    assign bus.bus_rs     = busRs;
    assign bus.bus_en     = busEn;
    assign bus.bus_cs     = busCs;
    assign bus.pix_ready  = (state == WAIT_PIX);
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = (state == DONE);
endmodule

// File: doc/plane_bus_master.md
Name: plane_bus_master

Overview:
- Drives the shared plane-load bus that feeds the per-plane PWM controllers of the LED cube.
- Takes a stream of brightness values from the frame source and issues the full per-plane command/data sequence:
  - set increment mode
  - set address 0
  - OUT_NUM data writes
  - enable PWM
- Plane sequencing is via one-hot chip select.
- Also issues a broadcast clear-memory command on request.

Parameters:
PLANES, 8, number of plane controllers on the bus (one bus_cs bit each)
OUT_NUM, 64, outputs per plane; must be <= 2^(D_WIDTH-1)
D_WIDTH, 8, bus data width
C_WIDTH, 5, brightness value width; zero-extended onto bus_data
STROBE_CYCLES, 2, cycles bus_en is held high per transaction (>=1)
HOLD_CYCLES, 1, cycles bus_en is low with bus_data/bus_rs/bus_cs unchanged after strobe (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
frame_start  in  1  one-cycle request to load a full frame (all planes)
clear_start  in  1  one-cycle request to broadcast clear-memory
pix_data  in  C_WIDTH  brightness value, plane-major, output-index order
pix_valid  in  1  pix_data valid
pix_ready  out  1  block accepts pix_data this cycle when pix_valid=1
busy  out  1  high from accepted start until return to IDLE
frame_done  out  1  one-cycle pulse when a frame or clear sequence completes
bus_data  out  D_WIDTH  command/data byte
bus_rs  out  1  1 = command, 0 = memory data
bus_en  out  1  strobe; receivers latch bus_data/bus_rs on its falling edge
bus_cs  out  PLANES  one-hot plane select; all ones for broadcast

Behaviour:
- Reset (reset=0 at clock edge):
  - Returns to IDLE.
  - All outputs 0: bus_data, bus_rs, bus_en, bus_cs, pix_ready, busy, frame_done.
- Reset mid-frame:
  - bus_en drops the next edge.
  - The partial transaction may be latched by receivers; this is acceptable because receivers share the reset.
- Command encoding:
  - 0x01 clear memory
  - 0x06 increment mode
  - 0x80|addr set address (0x80 for addr 0)
  - 0x0C PWM enable
- Transaction timing:
  - On the edge that launches a transaction, bus_data, bus_rs, bus_cs and bus_en=1 all update together.
  - bus_en stays high exactly STROBE_CYCLES cycles, then low for HOLD_CYCLES cycles with bus_data/bus_rs/bus_cs unchanged.
  - Transaction length = STROBE_CYCLES+HOLD_CYCLES cycles; back-to-back transactions have no extra gap.
- States: IDLE, CMD, WAIT_PIX, STROBE, HOLD, DONE.
- IDLE:
  - busy=0.
  - clear_start=1 -> CLEAR sequence; else frame_start=1 -> FRAME sequence.
  - Both high in the same cycle: clear wins and frame_start is dropped, not queued.
  - Starts while busy are ignored.
- CLEAR sequence: one command transaction, 0x01 with bus_cs all ones, then DONE.
- FRAME sequence, for plane p = 0..PLANES-1 with bus_cs = 1<<p:
  - CMD 0x06, CMD 0x80.
  - OUT_NUM data writes.
  - CMD 0x0C.
- Data write:
  - In WAIT_PIX, pix_ready=1 with bus_en=0.
  - On pix_valid&pix_ready: bus_data <= zero-extended pix_data, bus_rs <= 0, bus_en <= 1, enter STROBE.
  - pix_valid=0 stalls in WAIT_PIX indefinitely; previous bus values are held and bus_en stays 0.
  - pix_ready is 0 in every state except WAIT_PIX.
- Counters:
  - Pixel counter: 0..OUT_NUM-1, wraps to 0 at plane change.
  - Plane counter: 0..PLANES-1.
  - Strobe/hold counter: width >= clog2(max(STROBE_CYCLES,HOLD_CYCLES)+1).
- DONE (one cycle):
  - frame_done=1.
  - bus_cs, bus_data and bus_rs return to 0.
  - Next state IDLE.
- busy:
  - Goes high the edge after a start is accepted.
  - Stays high through DONE.
  - Is 0 in the cycle after DONE.
- Unstalled frame length = PLANES*(OUT_NUM+3)*(STROBE_CYCLES+HOLD_CYCLES) cycles from first bus_en rise to DONE.

Test Plan (PLANES=2, OUT_NUM=4, STROBE_CYCLES=2, HOLD_CYCLES=1; bench model of two receivers latching on falling bus_en gated by bus_cs):
- Clear: pulse clear_start -> one transaction with bus_data=0x01, bus_rs=1, bus_cs=2'b11, bus_en high 2 cycles; frame_done pulses once; busy low after.
- Full frame, pix_valid tied high, values 1..8 -> per plane: 0x06, 0x80, four data writes, 0x0C. Then:
  - receiver 0 memory = 1,2,3,4 and receiver 1 memory = 5,6,7,8;
  - both PWM enabled;
  - 42 cycles from first bus_en rise to DONE.
- Stall: deassert pix_valid for 5 cycles before pixel 3 -> bus_en stays 0 and pix_ready stays 1 during the stall; frame completes 5 cycles later with identical memory contents.
- Start arbitration: frame_start and clear_start in the same cycle -> only the clear sequence runs. frame_start asserted while busy -> ignored, exactly one frame_done.
- Reset mid-frame: assert reset during plane 1 data write -> next edge all outputs 0 and state IDLE. A following frame_start runs a complete, correct frame.
- Width: pix_data=5'h1F -> bus_data=0x1F with upper bits 0; bus_data/bus_rs stable across the full strobe and hold window of every transaction.
